// File: rtl/vec_popcount_if.sv
// rtl/vec_popcount_if.sv - valid/ready handshake bundle for the vector popcount pipeline
interface vec_popcount_if #(
  parameter int VEC_WIDTH    = 1100,
  parameter int POPCNT_WIDTH = $clog2(VEC_WIDTH + 1)
);
  logic [VEC_WIDTH-1:0]    vec;
  logic                    in_valid;
  logic                    this_ready;
  logic                    out_valid;
  logic                    next_ready;
  logic [POPCNT_WIDTH-1:0] popcount;

  modport master (
    output vec, in_valid, next_ready,
    input  this_ready, out_valid, popcount
  );

  modport slave (
    input  vec, in_valid, next_ready,
    output this_ready, out_valid, popcount
  );
endinterface

// File: rtl/vec_popcount.sv
// rtl/vec_popcount.sv - pipelined popcount: per-chunk counts, then a registered binary adder tree
module vec_popcount #(
  parameter int VEC_WIDTH    = 1100,
  parameter int LUT_WIDTH    = 6,
  parameter int POPCNT_WIDTH = $clog2(VEC_WIDTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  vec_popcount_if.slave bus
);
  localparam int NCHUNK         = (VEC_WIDTH + LUT_WIDTH - 1) / LUT_WIDTH;
  localparam int PIPELINE_DEPTH = $clog2(NCHUNK) + 1;
  localparam int PADW           = NCHUNK * LUT_WIDTH;

  function automatic logic [POPCNT_WIDTH-1:0] chunk_ones(input logic [LUT_WIDTH-1:0] bits);
    logic [POPCNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int b = 0; b < LUT_WIDTH; b++) begin
      cnt = cnt + POPCNT_WIDTH'(bits[b]);
    end
    return cnt;
  endfunction

  logic                      advance;
  logic [PADW-1:0]           vec_pad;
  logic [PIPELINE_DEPTH-1:0] vld_d;
  logic [PIPELINE_DEPTH-1:0] vld_q;
  logic [POPCNT_WIDTH-1:0]   tree_d [PIPELINE_DEPTH][NCHUNK];
  logic [POPCNT_WIDTH-1:0]   tree_q [PIPELINE_DEPTH][NCHUNK];

  // One global enable: every stage moves together, so a held output freezes the whole pipe.
  assign advance        = !bus.out_valid || bus.next_ready;
  assign bus.this_ready = advance;
  assign vec_pad        = PADW'(bus.vec);
  assign vld_d[0]       = bus.in_valid;

  for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
    assign tree_d[0][c] = chunk_ones(vec_pad[c*LUT_WIDTH +: LUT_WIDTH]);
  end

  for (genvar l = 1; l < PIPELINE_DEPTH; l++) begin : g_lvl
    localparam int NP = (NCHUNK + (1 << (l - 1)) - 1) >> (l - 1);
    localparam int N  = (NCHUNK + (1 << l) - 1) >> l;
    assign vld_d[l] = vld_q[l-1];
    for (genvar i = 0; i < NCHUNK; i++) begin : g_node
      if (i >= N) begin : g_unused
        assign tree_d[l][i] = '0;
      end else if (2 * i + 1 < NP) begin : g_pair
        assign tree_d[l][i] = tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
      end else begin : g_pass
        // Odd leftover of the previous level is carried forward unchanged.
        assign tree_d[l][i] = tree_q[l-1][2*i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int l = 0; l < PIPELINE_DEPTH; l++) begin
        for (int i = 0; i < NCHUNK; i++) begin
          tree_q[l][i] <= '0;
        end
      end
    end else if (advance) begin
      vld_q  <= vld_d;
      tree_q <= tree_d;
    end
  end

  assign bus.out_valid = vld_q[PIPELINE_DEPTH-1];
  assign bus.popcount  = tree_q[PIPELINE_DEPTH-1][0];
endmodule

// File: tb/tb_vec_popcount.sv
// tb/tb_vec_popcount.sv - randomized self-checking bench for vec_popcount against a counting model
module tb_vec_popcount;
  localparam int W     = 1100;
  localparam int PW    = $clog2(W + 1);
  localparam int DEPTH = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_popcount_if #(.VEC_WIDTH(W)) bus();
  vec_popcount #(.VEC_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int tot_in = 0;
  int tot_out = 0;
  int exp_q[$];
  int got_q[$];
  int in_cyc_q[$];
  int out_cyc_q[$];
  logic         s_in_hs = 1'b0;
  logic         s_out_hs = 1'b0;
  logic [W-1:0] s_vec;
  logic [PW-1:0] s_pop;

  function automatic int ref_count(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [1151:0] t;
    logic [1151:0] m;
    int mode = int'($urandom_range(0, 3));
    for (int k = 0; k < 36; k++) begin
      t[k*32 +: 32] = $urandom;
      m[k*32 +: 32] = $urandom;
    end
    if (mode == 1) t = t & m;
    if (mode == 2) t = t | m;
    if (mode == 3) t = '0;
    if (mode == 3) t[$urandom_range(0, W-1)] = 1'b1;
    return t[W-1:0];
  endfunction

  always @(negedge clk) begin
    s_in_hs  = rst_n && bus.in_valid && bus.this_ready;
    s_out_hs = rst_n && bus.out_valid && bus.next_ready;
    s_vec    = bus.vec;
    s_pop    = bus.popcount;
    if (bus.out_valid === 1'b1) ov_cnt++;
  end

  always @(posedge clk) begin
    if (s_in_hs) begin
      exp_q.push_back(ref_count(s_vec));
      in_cyc_q.push_back(cyc);
      tot_in++;
    end
    if (s_out_hs) begin
      got_q.push_back(int'(s_pop));
      out_cyc_q.push_back(cyc);
      tot_out++;
    end
    s_in_hs  = 1'b0;
    s_out_hs = 1'b0;
    cyc++;
  end

  task automatic step(input logic [W-1:0] v, input logic iv, input logic nr);
    @(posedge clk);
    #2;
    bus.vec = v;
    bus.in_valid = iv;
    bus.next_ready = nr;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    in_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    step('0, 1'b0, 1'b1);
    while (exp_q.size() != got_q.size() && n < 100) begin
      step('0, 1'b0, 1'b1);
      n++;
    end
    n_tests++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL drain_timeout: outputs=%0d required=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.vec = '1;
    bus.in_valid = 1'b1;
    bus.next_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      n_tests += 2;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
      end
      if (bus.popcount !== '0) begin
        n_fail++;
        $display("FAIL reset_popcount: got %0d required 0", bus.popcount);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.next_ready = 1'b1;
    clear_queues();
    tot_in = 0;
    tot_out = 0;
    @(negedge clk);
    n_tests++;
    if (bus.this_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_this_ready: got %b required 1", bus.this_ready);
    end
  endtask

  task automatic test_single_zero();
    clear_queues();
    ov_cnt = 0;
    step('0, 1'b1, 1'b1);
    repeat (20) step('0, 1'b0, 1'b1);
    n_tests += 2;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("FAIL zero_count: got %0d outputs required 1", got_q.size());
    end else begin
      if (got_q[0] != 0) begin
        n_fail++;
        $display("FAIL zero_value: got %0d required 0", got_q[0]);
      end
      n_tests++;
      if (out_cyc_q[0] - in_cyc_q[0] != DEPTH) begin
        n_fail++;
        $display("FAIL zero_latency: got %0d required %0d", out_cyc_q[0] - in_cyc_q[0], DEPTH);
      end
    end
    if (ov_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_valid_cycles: got %0d required 1", ov_cnt);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] pats [3];
    int want [3] = '{1100, 158, 550};
    pats[0] = '1;
    pats[1] = '0;
    pats[2] = '0;
    for (int i = 0; i < W; i++) begin
      if (i % 7 == 0) pats[1][i] = 1'b1;
      if (i % 2 == 0) pats[2][i] = 1'b1;
    end
    clear_queues();
    for (int p = 0; p < 3; p++) step(pats[p], 1'b1, 1'b1);
    drain();
    n_tests++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL pattern_count: got %0d outputs required 3", got_q.size());
    end else begin
      for (int p = 0; p < 3; p++) begin
        n_tests++;
        if (got_q[p] != want[p]) begin
          n_fail++;
          $display("FAIL pattern_%0d: got %0d required %0d", p, got_q[p], want[p]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] v;
    logic [PW-1:0] held;
    logic seen_block = 1'b0;
    v = W'(64'hAAAA_AAAA_AAAA_AAAA);
    clear_queues();
    for (int k = 0; k < 16; k++) begin
      step(v, k < 14, !(k >= 10 && k < 14));
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.next_ready === 1'b0) begin
        seen_block = 1'b1;
        n_tests += 2;
        if (bus.this_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_this_ready: got %b required 0", bus.this_ready);
        end
        if (k > 10 && bus.popcount !== held) begin
          n_fail++;
          $display("FAIL bp_stable: got %0d required %0d", bus.popcount, held);
        end
        held = bus.popcount;
      end
    end
    drain();
    n_tests += 2;
    if (!seen_block) begin
      n_fail++;
      $display("FAIL bp_stall_seen: got 0 required 1");
    end
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] != 32) begin
          n_fail++;
          $display("FAIL bp_value_%0d: got %0d required 32", i, got_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    for (int k = 0; k < 3; k++) step(W'($urandom), 1'b1, 1'b1);
    drain();
    n_tests++;
    if (got_q.size() != 3 || in_cyc_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d outputs required 3", got_q.size());
    end else begin
      n_tests++;
      if (out_cyc_q[0] - in_cyc_q[0] != DEPTH) begin
        n_fail++;
        $display("FAIL b2b_latency: got %0d required %0d", out_cyc_q[0] - in_cyc_q[0], DEPTH);
      end
      for (int i = 0; i < 3; i++) begin
        n_tests += 2;
        if (got_q[i] != exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_value_%0d: got %0d required %0d", i, got_q[i], exp_q[i]);
        end
        if (out_cyc_q[i] != out_cyc_q[0] + i) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: got cycle %0d required %0d", i, out_cyc_q[i], out_cyc_q[0] + i);
        end
      end
    end
  endtask

  task automatic test_random_stall();
    logic prev_ov = 1'b0;
    logic prev_nr = 1'b1;
    logic [PW-1:0] prev_pop = '0;
    clear_queues();
    for (int k = 0; k < 300; k++) begin
      step(rand_vec(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_ov && !prev_nr) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.popcount !== prev_pop) begin
          n_fail++;
          $display("FAIL rs_hold: got valid=%b pop=%0d required valid=1 pop=%0d", bus.out_valid, bus.popcount, prev_pop);
        end
      end
      prev_ov = bus.out_valid;
      prev_nr = bus.next_ready;
      prev_pop = bus.popcount;
    end
    drain();
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rs_count: got %0d outputs required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] != exp_q[i]) begin
          n_fail++;
          $display("FAIL rs_value_%0d: got %0d required %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int k = 0; k < 25; k++) begin
      step(rand_vec(), 1'b0, $urandom_range(0, 1) != 0);
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    n_tests += 2;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_out_valid: got %0d valid cycles required 0", bad);
    end
    if (tot_in != tot_out) begin
      n_fail++;
      $display("FAIL idle_handshakes: got %0d outputs required %0d", tot_out, tot_in);
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    for (int k = 0; k < 5; k++) step(rand_vec(), 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    ov_cnt = 0;
    clear_queues();
    tot_in = 0;
    tot_out = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (25) step('0, 1'b0, 1'b1);
    n_tests += 2;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL rm_stale_outputs: got %0d required 0", got_q.size());
    end
    if (ov_cnt != 0) begin
      n_fail++;
      $display("FAIL rm_out_valid: got %0d valid cycles required 0", ov_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.vec = '0;
    bus.in_valid = 1'b0;
    bus.next_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_zero();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    test_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_popcount.md
VEC_POPCOUNT -- requirements
Module: vec_popcount

Interface
REQ-001 Parameter VEC_WIDTH, default 1100, is the input vector width in bits and SHALL be at least 1.
REQ-002 Parameter LUT_WIDTH, default 6, is the number of bits counted per first-stage chunk.
REQ-003 Parameter POPCNT_WIDTH, default $clog2(VEC_WIDTH+1), is the result width and SHALL hold VEC_WIDTH without overflow.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port vec, input, VEC_WIDTH bits: the vector to count; it is sampled on an input handshake.
REQ-007 Port in_valid, input, 1 bit: vec is valid this cycle.
REQ-008 Port this_ready, output, 1 bit: the block accepts input this cycle.
REQ-009 Port out_valid, output, 1 bit: popcount is valid this cycle.
REQ-010 Port next_ready, input, 1 bit: downstream accepts output this cycle.
REQ-011 Port popcount, output, POPCNT_WIDTH bits: the number of 1 bits in the accepted vec.

Function
REQ-012 Input handshake SHALL occur on a rising edge where in_valid=1 and this_ready=1; output handshake SHALL occur on a rising edge where out_valid=1 and next_ready=1.
REQ-013 Stage 1 SHALL split vec into NCHUNK=ceil(VEC_WIDTH/LUT_WIDTH) chunks of LUT_WIDTH bits, starting at bit 0; the last chunk SHALL be zero-padded.
REQ-014 Stage 1 SHALL register the popcount of each chunk.
REQ-015 The following stages SHALL form a registered binary adder tree: each stage adds pairs, and an odd leftover SHALL pass through registered unchanged.
REQ-016 Pipeline depth SHALL be PIPELINE_DEPTH = $clog2(NCHUNK)+1 register stages; with defaults, NCHUNK=184 and PIPELINE_DEPTH=9.
REQ-017 Latency: with next_ready held at 1, out_valid SHALL assert exactly PIPELINE_DEPTH cycles after the input handshake edge.
REQ-018 Result: popcount SHALL equal the exact count of ones in the accepted vec, in the range 0..VEC_WIDTH.
REQ-019 Each pipeline stage SHALL carry a valid bit alongside its data; out_valid SHALL equal the last stage's valid bit.
REQ-020 Stall rule: the whole pipeline SHALL advance when advance = (!out_valid || next_ready), and SHALL hold all data and valid bits otherwise.
REQ-021 this_ready SHALL be combinational and equal to advance.
REQ-022 When the pipeline advances without an input handshake, stage 1 SHALL load valid=0 (a bubble).
REQ-023 Throughput: one result per cycle SHALL be sustained when in_valid=1 and next_ready=1 continuously.
REQ-024 Results SHALL be delivered in input order, with no loss, duplication or reordering, under any pattern of next_ready.
REQ-025 While out_valid=1 and next_ready=0, popcount and out_valid SHALL remain stable.
REQ-026 Simultaneous input and output handshakes in one cycle SHALL both complete.
REQ-027 popcount is don't-care when out_valid=0; an implementation MAY leave it at the last value.

Reset
REQ-028 While rst_n=0 at a rising edge, all stage valid bits SHALL clear, out_valid SHALL be 0 and popcount SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all in-flight results, and no stale output SHALL appear after release.
REQ-030 After reset, this_ready SHALL be 1, since out_valid=0.
REQ-031 No input SHALL be accepted on a cycle where rst_n=0.

Verification
REQ-032 Reset, then a single all-zero vec -> exactly one output, popcount=0, 9 cycles after the handshake; out_valid=0 on all other cycles.
REQ-033 Single all-ones vec -> popcount=1100; then a vec with every 7th bit set (bit 0, 7, ... 1099) -> popcount=158.
REQ-034 Alternating bits (even indices set) -> popcount=550.
REQ-035 Backpressure: present vec=64'hAAAA_AAAA_AAAA_AAAA zero-extended with next_ready=0 for 4 cycles, then release -> each value accepted during the stall is output once, popcount=32 each, in order, with no loss; this_ready=0 while a held output blocks.
REQ-036 Three back-to-back random 32-bit zero-extended inputs with next_ready=1 -> three consecutive outputs matching each input's count, starting 9 cycles after the first handshake.
REQ-037 Idle: in_valid=0 for 20 or more cycles after the pipeline drains -> out_valid stays 0, and the output handshake count equals the input handshake count.
